// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage pre-add/multiply/post-add MAC pipeline with P feedback and cascade ports.
// Define DSP_MAC_SAT_EN for signed post-adder saturation; otherwise P wraps and sat stays 0.
module dsp_mac_pipe #(
    parameter int AW = 18,
    parameter int PW = 48
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ce,
    input  logic            in_valid,
    input  logic [AW-1:0]   a,
    input  logic [AW-1:0]   b,
    input  logic [AW-1:0]   d,
    input  logic [PW-1:0]   c,
    input  logic [PW-1:0]   pcin,
    input  logic            carryin,
    input  logic [7:0]      opmode,
    output logic            out_valid,
    output logic [PW-1:0]   p,
    output logic [PW-1:0]   pcout,
    output logic [2*AW-1:0] m,
    output logic [AW-1:0]   bcout,
    output logic            carryout,
    output logic            sat
);
    logic [AW-1:0]   a1, b1, d1, a2, b2, pre;
    logic [PW-1:0]   c1, c2, c3, pcin1, pcin2, pcin3;
    logic [7:0]      op1;
    logic [4:0]      md2, md3;
    logic            ci1, cin2, cin3, v1, v2, v3;
    logic [2*AW-1:0] prod;
    logic [PW-1:0]   mx, x, z, pn;
    logic [PW:0]     xc, sum;
    logic            co, sn;

    assign pre   = op1[6] ? d1 - b1 : d1 + b1;
    assign prod  = {{AW{a2[AW-1]}}, a2} * {{AW{b2[AW-1]}}, b2};
    assign pcout = p;
    assign bcout = b2;

    // md3 = {subtract, Z select, X select}; X/Z = 2 read p before this edge's update
    always_comb begin
        mx  = {{(PW-2*AW){m[2*AW-1]}}, m};
        x   = md3[1:0] == 2'd0 ? '0 : md3[1:0] == 2'd1 ? mx : md3[1:0] == 2'd2 ? p : c3;
        z   = md3[3:2] == 2'd0 ? '0 : md3[3:2] == 2'd1 ? pcin3 : md3[3:2] == 2'd2 ? p : c3;
        xc  = {1'b0, x} + {{PW{1'b0}}, cin3};
        sum = md3[4] ? {1'b0, z} - xc : {1'b0, z} + xc;
        co  = sum[PW];
    end

`ifdef DSP_MAC_SAT_EN
    logic [PW:0] ws;
    assign ws = md3[4] ? {z[PW-1], z} - {x[PW-1], x} - {{PW{1'b0}}, cin3}
                       : {z[PW-1], z} + {x[PW-1], x} + {{PW{1'b0}}, cin3};
    assign sn = ws[PW] ^ ws[PW-1];
    assign pn = sn ? {ws[PW], {(PW-1){~ws[PW]}}} : ws[PW-1:0];
`else
    assign sn = 1'b0;
    assign pn = sum[PW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; pcin1 <= '0; op1 <= '0; ci1 <= 1'b0; v1 <= 1'b0;
            a2 <= '0; b2 <= '0; c2 <= '0; pcin2 <= '0; md2 <= '0; cin2 <= 1'b0; v2 <= 1'b0;
            m <= '0; c3 <= '0; pcin3 <= '0; md3 <= '0; cin3 <= 1'b0; v3 <= 1'b0;
            p <= '0; carryout <= 1'b0; sat <= 1'b0; out_valid <= 1'b0;
        end else if (ce) begin
            a1 <= a; b1 <= b; d1 <= d; c1 <= c; pcin1 <= pcin; op1 <= opmode; ci1 <= carryin; v1 <= in_valid;
            a2 <= a1; b2 <= op1[4] ? pre : b1; c2 <= c1; pcin2 <= pcin1;
            md2 <= {op1[7], op1[3:0]}; cin2 <= ci1 & op1[5]; v2 <= v1;
            m <= prod; c3 <= c2; pcin3 <= pcin2; md3 <= md2; cin3 <= cin2; v3 <= v2;
            out_valid <= v3;
            if (v3) begin
                p        <= pn;
                carryout <= co;
                sat      <= sn;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed vectors with a scoreboard queue checked by a separate output monitor.
module tb_dsp_mac_pipe;
    localparam int AW = 18;
    localparam int PW = 48;

    logic            clk = 1'b0, rstn = 1'b0, ce = 1'b1, in_valid = 1'b0, carryin = 1'b0;
    logic [AW-1:0]   a = '0, b = '0, d = '0;
    logic [PW-1:0]   c = '0, pcin = '0;
    logic [7:0]      opmode = '0;
    logic            out_valid, carryout, sat;
    logic [PW-1:0]   p, pcout;
    logic [2*AW-1:0] m;
    logic [AW-1:0]   bcout;

    typedef struct {
        logic [PW-1:0] p;
        logic          co;
        logic          sat;
        int            edge_n;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, edges = 0;
    logic adv = 1'b0;

`ifdef DSP_MAC_SAT_EN
    localparam logic [PW-1:0] SAT_P = 48'h7FFF_FFFF_FFFF;
    localparam logic          SAT_S = 1'b1;
`else
    localparam logic [PW-1:0] SAT_P = 48'h8000_0000_0000;
    localparam logic          SAT_S = 1'b0;
`endif

    dsp_mac_pipe #(.AW(AW), .PW(PW)) dut (
        .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .carryin(carryin), .opmode(opmode),
        .out_valid(out_valid), .p(p), .pcout(pcout), .m(m), .bcout(bcout),
        .carryout(carryout), .sat(sat)
    );

    always #5 clk = ~clk;

    // enabled-edge count gives latency in CE-qualified edges
    always @(posedge clk) begin
        if (rstn && ce) edges <= edges + 1;
        adv <= rstn && ce;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (adv && out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                e = q.pop_front();
                chk("p", 64'(p), 64'(e.p));
                chk("pcout", 64'(pcout), 64'(e.p));
                chk("carryout", 64'(carryout), 64'(e.co));
                chk("sat", 64'(sat), 64'(e.sat));
                chk("latency", 64'(edges - e.edge_n), 64'(4));
            end
        end
    end

    task automatic issue(input logic [AW-1:0] ia, ib, id, input logic [PW-1:0] ic, ipc,
                         input logic ici, input logic [7:0] iop,
                         input logic [PW-1:0] ep, input logic eco, esat);
        a = ia; b = ib; d = id; c = ic; pcin = ipc; carryin = ici; opmode = iop; in_valid = 1'b1;
        q.push_back('{p: ep, co: eco, sat: esat, edge_n: edges});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_p"}, 64'(p), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_m"}, 64'(m), 64'(0));
        chk({tag, "_bcout"}, 64'(bcout), 64'(0));
        chk({tag, "_carryout"}, 64'(carryout), 64'(0));
        chk({tag, "_sat"}, 64'(sat), 64'(0));
    endtask

    initial begin
        idle(2);
        chk_cleared("reset");
        rstn = 1'b1;
        idle(1);
        // C + A*(D+B) + cin = 4 + 18 + 1
        issue(2, 3, 6, 4, 0, 1, 8'h3D, 23, 0, 0);
        idle(1);
        chk("bcout_preadd", 64'(bcout), 64'(9));
        idle(1);
        chk("m_product", 64'(m), 64'(18));
        idle(4);
        issue(4, 1, 15, 0, 0, 1, 8'h71, 57, 0, 0);
        issue(4, 1, 15, 0, 0, 1, 8'hF1, 48'hFFFF_FFFF_FFC7, 1, 0);
        issue(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0);
        for (int k = 1; k <= 4; k++) issue(2, 3, 0, 0, 0, 0, 8'h09, PW'(6 * k), 0, 0);
        issue(0, 0, 0, 0, 0, 1, 8'h2A, 49, 0, 0);
        issue(0, 0, 0, 0, 0, 1, 8'hAA, 48'hFFFF_FFFF_FFFF, 1, 0);
        issue(0, 0, 0, 23, 100, 0, 8'h07, 123, 0, 0);
        issue(0, 0, 0, 48'hFFFF_FFFF_FFFF, 2, 0, 8'h07, 1, 1, 0);
        issue(1, 1, 18'h1FFFF, 0, 0, 0, 8'h11, 48'hFFFF_FFFE_0000, 0, 0);
        idle(5);
        issue(2, 3, 6, 4, 0, 1, 8'h3D, 23, 0, 0);
        ce = 1'b0;
        idle(3);
        ce = 1'b1;
        idle(3);
        ce = 1'b0;
        idle(2);
        chk("stall_out_valid_hold", 64'(out_valid), 64'(1));
        chk("stall_p_hold", 64'(p), 64'(23));
        ce = 1'b1;
        idle(2);
        issue(2, 3, 6, 4, 0, 1, 8'h3D, 23, 0, 0);
        issue(4, 1, 15, 0, 0, 1, 8'h71, 57, 0, 0);
        rstn = 1'b0;
        q.delete();
        idle(1);
        chk_cleared("midreset");
        rstn = 1'b1;
        idle(6);
        issue(2, 3, 6, 4, 0, 1, 8'h3D, 23, 0, 0);
        idle(5);
        issue(0, 0, 0, 48'h7FFF_FFFF_FFFF, 0, 1, 8'h2C, SAT_P, 0, SAT_S);
        idle(5);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameter AW, 18, width of A, B, D, BCOUT; legal 4..25.
REQ-002 Parameter PW, 48, width of C, PCIN, P, PCOUT; SHALL satisfy PW >= 2*AW+1.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RSTN  in  1  reset, synchronous, active-low.
REQ-005 CE  in  1  global pipeline enable; 0 freezes every register.
REQ-006 IN_VALID  in  1  operand set valid this cycle.
REQ-007 A, B, D  in  AW  signed two's-complement operands.
REQ-008 C, PCIN  in  PW  post-adder operands.
REQ-009 CARRYIN  in  1  carry input.
REQ-010 OPMODE  in  8  per-operation mode, sampled with operands.
REQ-011 OUT_VALID  out  1  P/CARRYOUT/SAT hold a new result.
REQ-012 P, PCOUT  out  PW  result; PCOUT identical to P.
REQ-013 M  out  2*AW  multiplier register.
REQ-014 BCOUT  out  AW  stage-2 B' register.
REQ-015 CARRYOUT  out  1  post-adder carry/borrow.
REQ-016 SAT  out  1  saturation occurred on current result.

Function
REQ-017 OPMODE[1:0] X select: 0 zero, 1 M sign-extended to PW, 2 P register, 3 C.
REQ-018 OPMODE[3:2] Z select: 0 zero, 1 PCIN, 2 P register, 3 C.
REQ-019 OPMODE[4]=1 B' = pre-adder result, 0 B' = B; OPMODE[6]=1 pre-adder D-B, 0 D+B; pre-adder AW bits, wraps.
REQ-020 OPMODE[5] gates carry: cin = CARRYIN & OPMODE[5].
REQ-021 OPMODE[7]=0 P = Z + X + cin; 1 P = Z - (X + cin); modulo 2^PW.
REQ-022 CARRYOUT: add -> bit PW of unsigned PW+1-bit sum; sub -> 1 when Z < X+cin (unsigned).
REQ-023 Pipeline, 4 stages, each advancing only when CE=1: S1 registers A, B, D, C, PCIN, OPMODE, CARRYIN, valid; S2 registers A, B', C, PCIN, mode, cin, valid; S3 registers M = A*B' (signed, 2*AW bits), C, PCIN, mode, cin, valid; S4 registers P, CARRYOUT, SAT, OUT_VALID.
REQ-024 Latency exactly 4 CE-enabled edges from IN_VALID sampled to OUT_VALID=1; throughput one operation per cycle.
REQ-025 P feedback (X or Z = 2) uses P register value before the S4 update, so back-to-back valid accumulates consecutively.
REQ-026 Bubbles (valid=0) propagate; S4 with valid=0 holds P, CARRYOUT, SAT and drives OUT_VALID=0.
REQ-027 CE=0: all registers hold, OUT_VALID holds its value; IN_VALID ignored.
REQ-028 X=Z=2 simultaneously legal: P = 2*P (+cin) or 0 (-cin).

Reset
REQ-029 RSTN=0 at a rising edge clears every register (P, PCOUT, M, BCOUT, CARRYOUT, SAT, OUT_VALID, all stage data, valid bits) to 0, regardless of CE.
REQ-030 Reset mid-operation discards all in-flight operations; no OUT_VALID for them after release.
REQ-031 First IN_VALID after release yields OUT_VALID 4 edges later.

Configuration
REQ-032 Macro DSP_MAC_SAT_EN defined: post-adder treats Z, X as PW-bit signed; on signed overflow P clamps to 2^(PW-1)-1 (positive) or -2^(PW-1) (negative), SAT=1 with that result; CARRYOUT computed as REQ-022 unclamped.
REQ-033 Macro undefined: P wraps per REQ-021; SAT constant 0; no saturation logic.

Verification
REQ-034 AW=18, PW=48; A=2, B=3, D=6, C=4, CARRYIN=1, OPMODE=0x3D, IN_VALID one cycle -> 4 edges later OUT_VALID=1, P=23, M=18, CARRYOUT=0.
REQ-035 A=4, B=1, D=15, OPMODE=0x71, CARRYIN=1 -> P=57; then OPMODE=0xF1 with C... Z=0 -> P=-57 (0xFFFF_FFFF_FFC7), CARRYOUT=1.
REQ-036 Accumulate: A=2, B=3, OPMODE=0x09 (X=M, Z=P), IN_VALID 4 consecutive cycles from P=0 -> P=6, 12, 18, 24 on consecutive cycles, OUT_VALID high 4 cycles.
REQ-037 Same as REQ-034 with CE=0 for 3 cycles after issue -> OUT_VALID after 7 edges, P=23; RSTN=0 one edge with 2 ops in flight -> all outputs 0, no OUT_VALID follows.
REQ-038 C=0x7FFF_FFFF_FFFF, OPMODE=0x2C, CARRYIN=1 -> DSP_MAC_SAT_EN defined: P=0x7FFF_FFFF_FFFF, SAT=1; undefined: P=0x8000_0000_0000, SAT=0, CARRYOUT=0.
